wshb_arbiter: RTL and testbench
===============================

Name: wshb_arbiter

Overview:
- Two-master, one-slave Wishbone classic arbiter in front of the SDRAM controller.
- Master 0 is the VGA frame reader, which holds cyc permanently high. Master 1 is the frame writer (pattern generator / upstream source).
- Round-robin grant with a per-tenure transaction quota (MAX_HOLD), so the always-requesting reader cannot starve the writer.
- Sits in the wshb clock domain between the masters and the slave.

Parameters:
- MAX_HOLD, 16, acked transactions an owner may complete before the grant moves to the other master, if that master is requesting; legal range 1..255.
- ADDR_W, 32, address width.
- DATA_W, 32, data width; SEL_W = DATA_W/8.

Ports:
- clk  input  1  Wishbone clock
- rst  input  1  synchronous reset, active-high
- mN_cyc, mN_stb, mN_we (N=0,1)  input  1 each  master cycle / strobe / write-enable
- mN_adr  input  ADDR_W  master address
- mN_dat_ms  input  DATA_W  master write data
- mN_sel  input  SEL_W  master byte selects
- mN_dat_sm  output  DATA_W  read data to master
- mN_ack  output  1  acknowledge to master
- s_cyc, s_stb, s_we  output  1 each  to slave
- s_adr  output  ADDR_W  to slave
- s_dat_ms  output  DATA_W  to slave
- s_sel  output  SEL_W  to slave
- s_cti  output  3  to slave
- s_bte  output  2  to slave
- s_dat_sm  input  DATA_W  slave read data
- s_ack  input  1  slave acknowledge
- grant  output  2  one-hot current owner; 00 = none

Behaviour:
- Reset (sync, active-high): state IDLE, grant=00, last_owner=1 (master 0 wins the first contention), hold_cnt=0.
  - During and after reset: s_cyc=s_stb=s_we=0, s_adr=0, s_dat_ms=0, s_sel=0, m0_ack=m1_ack=0.
- Fixed outputs: s_cti=3'b000 and s_bte=2'b00 at all times (classic cycles only).
- FSM states: IDLE, OWN0, OWN1. grant is registered and equals the one-hot encoding of the state.
- Datapath: combinational mux selected by the registered grant.
  - s_cyc/stb/we/adr/dat_ms/sel = owner's signals.
  - With no owner, all of them are 0.
  - mN_dat_sm = s_dat_sm to both masters.
  - mN_ack = s_ack & grant[N].
  - Non-owner never sees ack; its pending stb simply waits.
- IDLE:
  - Only m0_cyc → OWN0. Only m1_cyc → OWN1.
  - Both → the master not equal to last_owner.
  - Neither → stay.
  - Nothing is forwarded during the IDLE cycle: 1-cycle grant latency.
- OWNk, checked in priority order:
  1. mk_cyc=0 → IDLE; last_owner=k; hold_cnt=0.
  2. s_ack=1 and other master's cyc=1 and hold_cnt==MAX_HOLD-1 → OWN(other) directly, no IDLE bubble; last_owner=k; hold_cnt=0.
  3. s_ack=1 otherwise → hold_cnt increments, saturating at MAX_HOLD-1.
  4. Otherwise → stay.
- Switching happens only at a transaction boundary (the ack cycle) or when the owner drops cyc. A strobe is never re-routed mid-transaction.
- Saturated hold_cnt: if the other master raises cyc later, the switch fires on the owner's next ack.
- Quota: with both masters busy, each tenure is exactly MAX_HOLD acks; MAX_HOLD=1 gives strict alternation per transaction.
- Width: hold_cnt is $clog2(MAX_HOLD+1) bits. Comparison and increment use that width; no wrap.
- s_ack while grant=00 (spurious): ignored; no master ack, no state change.
- Reset asserted mid-transaction:
  - Next edge → IDLE and grant=00, so all slave strobes drop.
  - An in-flight slave ack in the cycle after reset is not forwarded.

Test Plan:
- Reset then m0_cyc=m0_stb=1 only, slave acks every 2nd cycle → grant 00 → 01 one cycle later; m0_ack mirrors s_ack; m1_ack stays 0; grant stays 01 indefinitely.
- Both masters request from IDLE in the same cycle right after reset → grant=01. m0 drops cyc after 3 acks → IDLE, then grant=10 next cycle (round-robin).
- MAX_HOLD=4, m0 continuous, m1 raises cyc after m0's 2nd ack → grant switches 01→10 on the clock edge of m0's 4th ack. m0 sees exactly 4 acks, then waits with stb high; m1's adr/dat appear on s_* the next cycle.
- MAX_HOLD=1, both continuous, slave acks every cycle → grant alternates 01,10,01,… every cycle; ack counts per master differ by ≤1 over 100 cycles.
- m1 write (we=1, sel=4'b0011, adr=0x100, dat=0xDEADBEEF) while owner → s_we=1, s_sel=0011, s_adr=0x100, s_dat_ms=0xDEADBEEF; s_cti=000, s_bte=00.
- rst pulsed 1 cycle while OWN1 with stb pending, slave acks the following cycle → grant=00, s_cyc=0 after the edge; neither mN_ack asserts; next grant goes to m0 if both request.

Source files
------------

// File: rtl/wshb_arbiter.sv
// Two-master Wishbone classic arbiter in front of the SDRAM controller.
// Round-robin grant with a per-tenure ack quota so the reader cannot starve the writer.
module wshb_arbiter #(
  parameter int MAX_HOLD = 16,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  localparam int SEL_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_cyc,
  input  logic              m0_stb,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_adr,
  input  logic [DATA_W-1:0] m0_dat_ms,
  input  logic [SEL_W-1:0]  m0_sel,
  output logic [DATA_W-1:0] m0_dat_sm,
  output logic              m0_ack,
  input  logic              m1_cyc,
  input  logic              m1_stb,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_adr,
  input  logic [DATA_W-1:0] m1_dat_ms,
  input  logic [SEL_W-1:0]  m1_sel,
  output logic [DATA_W-1:0] m1_dat_sm,
  output logic              m1_ack,
  output logic              s_cyc,
  output logic              s_stb,
  output logic              s_we,
  output logic [ADDR_W-1:0] s_adr,
  output logic [DATA_W-1:0] s_dat_ms,
  output logic [SEL_W-1:0]  s_sel,
  output logic [2:0]        s_cti,
  output logic [1:0]        s_bte,
  input  logic [DATA_W-1:0] s_dat_sm,
  input  logic              s_ack,
  output logic [1:0]        grant
);

  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_t;

  state_t        state, state_n;
  logic          last_owner, last_n;
  logic [HW-1:0] hold_cnt, hold_n;
  logic [1:0]    sel;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_owner <= 1'b1;
      hold_cnt   <= '0;
    end else begin
      state      <= state_n;
      last_owner <= last_n;
      hold_cnt   <= hold_n;
    end
  end

  always_comb begin
    state_n = state;
    last_n  = last_owner;
    hold_n  = hold_cnt;
    unique case (state)
      IDLE: begin
        if (m0_cyc && m1_cyc)
          state_n = last_owner ? OWN0 : OWN1;
        else if (m0_cyc)
          state_n = OWN0;
        else if (m1_cyc)
          state_n = OWN1;
      end
      OWN0: begin
        if (!m0_cyc) begin
          state_n = IDLE;
          last_n  = 1'b0;
          hold_n  = '0;
        end else if (s_ack && m1_cyc && hold_cnt == HOLD_LAST) begin
          state_n = OWN1;
          last_n  = 1'b0;
          hold_n  = '0;
        end else if (s_ack && hold_cnt != HOLD_LAST) begin
          hold_n = hold_cnt + HW'(1);
        end
      end
      OWN1: begin
        if (!m1_cyc) begin
          state_n = IDLE;
          last_n  = 1'b1;
          hold_n  = '0;
        end else if (s_ack && m0_cyc && hold_cnt == HOLD_LAST) begin
          state_n = OWN0;
          last_n  = 1'b1;
          hold_n  = '0;
        end else if (s_ack && hold_cnt != HOLD_LAST) begin
          hold_n = hold_cnt + HW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign grant = state;
  // Reset masks the bus in the same cycle, ahead of the state register.
  assign sel = rst ? 2'b00 : state;

  always_comb begin
    s_cyc    = 1'b0;
    s_stb    = 1'b0;
    s_we     = 1'b0;
    s_adr    = '0;
    s_dat_ms = '0;
    s_sel    = '0;
    unique case (1'b1)
      sel[0]: begin
        s_cyc    = m0_cyc;
        s_stb    = m0_stb;
        s_we     = m0_we;
        s_adr    = m0_adr;
        s_dat_ms = m0_dat_ms;
        s_sel    = m0_sel;
      end
      sel[1]: begin
        s_cyc    = m1_cyc;
        s_stb    = m1_stb;
        s_we     = m1_we;
        s_adr    = m1_adr;
        s_dat_ms = m1_dat_ms;
        s_sel    = m1_sel;
      end
      default: ;
    endcase
  end

  assign m0_ack    = s_ack & sel[0];
  assign m1_ack    = s_ack & sel[1];
  assign m0_dat_sm = s_dat_sm;
  assign m1_dat_sm = s_dat_sm;
  assign s_cti     = 3'b000;
  assign s_bte     = 2'b00;

endmodule

// File: tb/tb_wshb_arbiter.sv
// Directed bench for wshb_arbiter: quota of 4 on the main instance,
// quota of 1 on a second instance for per-transaction alternation.
module tb_wshb_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic        rst;
  logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [31:0] m0_adr, m0_dat_ms, m1_adr, m1_dat_ms;
  logic [3:0]  m0_sel, m1_sel;
  logic [31:0] m0_dat_sm, m1_dat_sm;
  logic        m0_ack, m1_ack;
  logic        s_cyc, s_stb, s_we;
  logic [31:0] s_adr, s_dat_ms, s_dat_sm;
  logic [3:0]  s_sel;
  logic [2:0]  s_cti;
  logic [1:0]  s_bte;
  logic        s_ack;
  logic [1:0]  grant;

  wshb_arbiter #(.MAX_HOLD(4)) u4 (
    .clk(clk), .rst(rst),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we),
    .m0_adr(m0_adr), .m0_dat_ms(m0_dat_ms), .m0_sel(m0_sel),
    .m0_dat_sm(m0_dat_sm), .m0_ack(m0_ack),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we),
    .m1_adr(m1_adr), .m1_dat_ms(m1_dat_ms), .m1_sel(m1_sel),
    .m1_dat_sm(m1_dat_sm), .m1_ack(m1_ack),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we),
    .s_adr(s_adr), .s_dat_ms(s_dat_ms), .s_sel(s_sel),
    .s_cti(s_cti), .s_bte(s_bte),
    .s_dat_sm(s_dat_sm), .s_ack(s_ack), .grant(grant)
  );

  logic        a_rst, a_cyc, a_ack_in;
  logic [31:0] a_m0_dat_sm, a_m1_dat_sm, a_adr, a_dat_ms;
  logic        a_m0_ack, a_m1_ack, a_s_cyc, a_s_stb, a_s_we;
  logic [3:0]  a_s_sel;
  logic [2:0]  a_s_cti;
  logic [1:0]  a_s_bte, a_grant;

  wshb_arbiter #(.MAX_HOLD(1)) u1 (
    .clk(clk), .rst(a_rst),
    .m0_cyc(a_cyc), .m0_stb(a_cyc), .m0_we(1'b0),
    .m0_adr(32'h10), .m0_dat_ms(32'h0), .m0_sel(4'hf),
    .m0_dat_sm(a_m0_dat_sm), .m0_ack(a_m0_ack),
    .m1_cyc(a_cyc), .m1_stb(a_cyc), .m1_we(1'b1),
    .m1_adr(32'h20), .m1_dat_ms(32'h5), .m1_sel(4'hf),
    .m1_dat_sm(a_m1_dat_sm), .m1_ack(a_m1_ack),
    .s_cyc(a_s_cyc), .s_stb(a_s_stb), .s_we(a_s_we),
    .s_adr(a_adr), .s_dat_ms(a_dat_ms), .s_sel(a_s_sel),
    .s_cti(a_s_cti), .s_bte(a_s_bte),
    .s_dat_sm(32'h0), .s_ack(a_ack_in), .grant(a_grant)
  );

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    m0_cyc = 0; m0_stb = 0; m0_we = 0;
    m0_adr = 0; m0_dat_ms = 0; m0_sel = 0;
    m1_cyc = 0; m1_stb = 0; m1_we = 0;
    m1_adr = 0; m1_dat_ms = 0; m1_sel = 0;
    s_ack = 0; s_dat_sm = 0;
  endtask

  task automatic do_reset();
    clr();
    rst = 1;
    tick();
    rst = 0;
  endtask

  int n0, n1;
  logic [1:0] exp_g;

  initial begin
    rst = 1;
    clr();
    a_rst = 1; a_cyc = 0; a_ack_in = 0;

    // reset state, with a spurious ack and a requesting master
    m0_cyc = 1; m0_stb = 1; s_ack = 1;
    tick();
    #1;
    check("rst_grant", grant, 2'b00);
    check("rst_scyc", s_cyc, 0);
    check("rst_m0ack", m0_ack, 0);
    check("rst_sadr", s_adr, 0);

    // single master, slave acks every 2nd cycle
    rst = 0; s_ack = 1; m0_adr = 32'h40;
    #1;
    check("idle_grant", grant, 2'b00);
    check("idle_scyc", s_cyc, 0);
    check("idle_spur", m0_ack, 0);
    tick();
    check("own0_grant", grant, 2'b01);
    check("own0_adr", s_adr, 32'h40);
    n0 = 0;
    for (int i = 0; i < 8; i++) begin
      s_ack = i[0];
      #1;
      check("solo_m0ack", m0_ack, i[0]);
      check("solo_m1ack", m1_ack, 0);
      check("solo_grant", grant, 2'b01);
      tick();
    end

    // simultaneous request after reset, then m0 drops
    do_reset();
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h44;
    m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_sel = 4'b0011;
    m1_adr = 32'h100; m1_dat_ms = 32'hDEADBEEF;
    tick();
    check("both_grant", grant, 2'b01);
    for (int i = 0; i < 3; i++) begin
      s_ack = 1;
      #1;
      check("both_m0ack", m0_ack, 1);
      tick();
    end
    m0_cyc = 0; m0_stb = 0; s_ack = 0;
    tick();
    check("drop_idle", grant, 2'b00);
    check("drop_scyc", s_cyc, 0);
    tick();
    check("rr_grant", grant, 2'b10);

    // m1 write forwarded
    s_dat_sm = 32'hCAFE0001;
    #1;
    check("wr_we", s_we, 1);
    check("wr_sel", s_sel, 4'b0011);
    check("wr_adr", s_adr, 32'h100);
    check("wr_dat", s_dat_ms, 32'hDEADBEEF);
    check("wr_cti", s_cti, 3'b000);
    check("wr_bte", s_bte, 2'b00);
    check("rd_m0", m0_dat_sm, 32'hCAFE0001);
    check("rd_m1", m1_dat_sm, 32'hCAFE0001);

    // reset pulse while OWN1 with a pending strobe
    m0_cyc = 1; m0_stb = 1;
    rst = 1;
    #1;
    check("mid_rst_scyc", s_cyc, 0);
    check("mid_rst_m1ack", m1_ack, 0);
    tick();
    rst = 0; s_ack = 1;
    #1;
    check("post_rst_grant", grant, 2'b00);
    check("post_rst_scyc", s_cyc, 0);
    check("post_rst_m0ack", m0_ack, 0);
    check("post_rst_m1ack", m1_ack, 0);
    s_ack = 0;
    tick();
    check("post_rst_rr", grant, 2'b01);

    // quota of 4: m1 arrives after m0's 2nd ack
    do_reset();
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h200;
    m1_stb = 1; m1_adr = 32'h300;
    tick();
    check("q_grant0", grant, 2'b01);
    n0 = 0;
    for (int i = 0; i < 4; i++) begin
      m1_cyc = (i >= 2);
      s_ack = 1;
      #1;
      check("q_hold_grant", grant, 2'b01);
      n0 += int'(m0_ack);
      tick();
    end
    check("q_m0_acks", n0, 4);
    check("q_switch", grant, 2'b10);
    check("q_m0_wait", m0_ack, 0);
    check("q_m1_ack", m1_ack, 1);
    check("q_m1_adr", s_adr, 32'h300);
    repeat (4) tick();
    check("q_back", grant, 2'b01);

    // quota of 1: strict alternation
    a_cyc = 1; a_ack_in = 1;
    tick();
    a_rst = 0;
    tick();
    exp_g = 2'b01;
    n0 = 0; n1 = 0;
    for (int i = 0; i < 100; i++) begin
      check("alt_grant", a_grant, exp_g);
      n0 += int'(a_m0_ack);
      n1 += int'(a_m1_ack);
      tick();
      exp_g = (exp_g == 2'b01) ? 2'b10 : 2'b01;
    end
    check("alt_n0", n0, 50);
    check("alt_bal", ((n0 > n1) ? n0 - n1 : n1 - n0) <= 1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
